link_pump: RTL and testbench
============================

Name: link_pump

Overview:
- Active counterpart of the passive link inverter.
- The passive inverter only wires a put method to a get method and exposes readiness.
- link_pump is the initiator: it calls a source module's get method and a destination module's put method itself, moving words through a 2-entry buffer.
- Sits between two BSV-style EN/RDY method interfaces (e.g. a portal indication source and a consumer pipe) where neither side can initiate.

Parameters:
DATA_WIDTH, 32, width of one transferred word
CNT_WIDTH, 16, width of the delivered-word counter

Ports:
CLK  input  1  clock; all state updates on rising edge
RST  input  1  reset: synchronous, active-low (RST==0 at a rising CLK edge resets)
enable  input  1  1 = pump may pull from source; 0 = stop pulling, keep draining
src_data  input  DATA_WIDTH  source get-method return value, valid when src_RDY=1
src_RDY  input  1  source get-method ready
src_EN  output  1  pump invokes source get this cycle
dst_data  output  DATA_WIDTH  argument to destination put method (buffer head)
dst_RDY  input  1  destination put-method ready
dst_EN  output  1  pump invokes destination put this cycle
occupancy  output  2  words held in buffer, 0..2
delivered  output  CNT_WIDTH  count of words delivered via dst_EN

Behaviour:
- Storage:
  - 2-entry circular buffer with 1-bit read and write pointers and a 2-bit occupancy register.
  - No combinational path from src_data to dst_data; dst_data is always the registered head entry.
- Pull and push enables:
  - src_EN = RST & enable & src_RDY & (occupancy != 2).
  - dst_EN = RST & dst_RDY & (occupancy != 0).
  - Both are combinational from registered state plus the RDY inputs, which is legal under BSV EN-after-RDY rules.
- Enqueue: on an edge with src_EN=1, src_data is written at the write pointer and the write pointer toggles.
- Dequeue: on an edge with dst_EN=1, the read pointer toggles and delivered increments.
- Occupancy update:
  - src_EN only: +1.
  - dst_EN only: -1.
  - Both: unchanged, which sustains 1 word/cycle at occupancy 1.
  - Neither: unchanged.
- Full (occupancy==2): src_EN=0 even if dst_EN=1 the same cycle. There is no full-bypass; this yields one bubble cycle on the source side.
- Empty (occupancy==0): dst_EN=0 and dst_data holds the stale last entry; it has no meaning.
- Latency: a word taken at edge N is presented with dst_EN possible in cycle N+1, so minimum latency is 1 cycle.
- Ordering: words are delivered strictly in pull order; no drops or duplicates.
- delivered counter: wraps modulo 2^CNT_WIDTH with no saturation.
- enable deasserted: pulling stops the next combinational evaluation. Buffered words continue to drain and are delivered normally.
- Reset:
  - While RST==0, src_EN=0 and dst_EN=0 (gated combinationally), so no method fires during the reset cycle.
  - At the edge: occupancy=0, both pointers=0, delivered=0; buffer contents are not reset.
  - Reset mid-transfer discards buffered words. Source words already taken are lost; this is by design.
- After reset release: src_EN may assert in the first cycle with RST==1.

Test Plan:
- Reset then enable=1, src_RDY=1 every cycle with data 1,2,3,..., dst_RDY=1 -> first dst_EN one cycle after first src_EN; occupancy settles at 1; dst_data sequence 1,2,3,...; delivered increments every cycle.
- dst_RDY=0 with source always ready, then dst_RDY=1 -> two pulls (words A,B), occupancy=2, src_EN=0. After release: A then B delivered; one cycle with src_EN=0 and dst_EN=1 at occupancy 2; full rate resumes.
- Random src_RDY/dst_RDY (50%) for 1000 words -> scoreboard: delivered sequence equals pulled sequence; occupancy never exceeds 2; src_EN never high while occupancy==2; dst_EN never high while occupancy==0.
- Occupancy 2 then enable=0 with dst_RDY=1 -> src_EN stays 0; two words delivered; occupancy 0; delivered +2.
- Assert RST=0 for one cycle while occupancy=2 -> src_EN=dst_EN=0 that cycle; next cycle occupancy=0 and delivered=0; the first post-reset word delivered is the new source word.
- CNT_WIDTH=4, deliver 17 words -> delivered reads 0xF after 15 words, 0x0 after 16, 0x1 after 17.

Source files
------------

// File: rtl/link_pump_if.sv
// +-----------------------------------------------------------------------+
// | link_pump_if : EN/RDY method bundle between link_pump and its peers   |
// | Revision     : 1.0                                                    |
// +-----------------------------------------------------------------------+
`default_nettype none

interface link_pump_if #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
);
    logic                  enable;
    logic [DATA_WIDTH-1:0] src_data;
    logic                  src_RDY;
    logic                  src_EN;
    logic [DATA_WIDTH-1:0] dst_data;
    logic                  dst_RDY;
    logic                  dst_EN;
    logic [1:0]            occupancy;
    logic [CNT_WIDTH-1:0]  delivered;

    // master is the pump itself; slave is the surrounding environment
    modport master (
        input  enable, src_data, src_RDY, dst_RDY,
        output src_EN, dst_data, dst_EN, occupancy, delivered
    );

    modport slave (
        output enable, src_data, src_RDY, dst_RDY,
        input  src_EN, dst_data, dst_EN, occupancy, delivered
    );
endinterface

`default_nettype wire

// File: rtl/link_pump.sv
// +-----------------------------------------------------------------------+
// | link_pump : initiator that pulls a source get and pushes a dest put   |
// |             through a registered 2-entry buffer                       |
// | Revision  : 1.0                                                       |
// +-----------------------------------------------------------------------+
`default_nettype none

module link_pump #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  wire logic   CLK,
    input  wire logic   RST,
    link_pump_if.master lnk
);
    logic [DATA_WIDTH-1:0] buf_mem [2];
    logic                  wr_ptr;
    logic                  rd_ptr;
    logic [1:0]            occ;
    logic [CNT_WIDTH-1:0]  cnt;
    logic                  src_en;
    logic                  dst_en;

    // RST gating keeps both methods silent during the reset cycle
    assign src_en = RST & lnk.enable & lnk.src_RDY & (occ != 2'd2);
    assign dst_en = RST & lnk.dst_RDY & (occ != 2'd0);

    assign lnk.src_EN    = src_en;
    assign lnk.dst_EN    = dst_en;
    assign lnk.dst_data  = buf_mem[rd_ptr];
    assign lnk.occupancy = occ;
    assign lnk.delivered = cnt;

    // storage is deliberately not reset; only pointers and occupancy are
    always_ff @(posedge CLK) begin
        if (src_en) begin
            buf_mem[wr_ptr] <= lnk.src_data;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            occ    <= 2'd0;
            cnt    <= '0;
        end else begin
            if (src_en) begin
                wr_ptr <= ~wr_ptr;
            end
            if (dst_en) begin
                rd_ptr <= ~rd_ptr;
                cnt    <= cnt + CNT_WIDTH'(1);
            end
            case ({src_en, dst_en})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase
        end
    end
endmodule

`default_nettype wire

// File: tb/tb_link_pump.sv
// +-----------------------------------------------------------------------+
// | tb_link_pump : directed checks of link_pump plus a 4-bit counter copy |
// | Revision     : 1.0                                                    |
// +-----------------------------------------------------------------------+
`default_nettype none

module tb_link_pump;
    logic CLK;
    logic RST;

    int vectors = 0;
    int errs    = 0;

    link_pump_if #(.DATA_WIDTH(32), .CNT_WIDTH(16)) lnk ();
    link_pump_if #(.DATA_WIDTH(8),  .CNT_WIDTH(4))  lnk4 ();

    link_pump #(.DATA_WIDTH(32), .CNT_WIDTH(16)) dut (
        .CLK (CLK),
        .RST (RST),
        .lnk (lnk)
    );

    link_pump #(.DATA_WIDTH(8), .CNT_WIDTH(4)) dut4 (
        .CLK (CLK),
        .RST (RST),
        .lnk (lnk4)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    logic [31:0] sb_q[$];
    int          seq  = 1000;
    int          pops = 0;

    // one scoreboard cycle: inputs already applied, sample after settling
    task automatic sb_cycle;
        #1;
        chk("occ_le_2", 64'(lnk.occupancy <= 2'd2), 64'd1);
        chk("no_pull_full", 64'(lnk.src_EN & (lnk.occupancy == 2'd2)), 64'd0);
        chk("no_push_empty", 64'(lnk.dst_EN & (lnk.occupancy == 2'd0)), 64'd0);
        if (lnk.dst_EN) begin
            if (sb_q.size() == 0) begin
                chk("sb_underflow", 64'd1, 64'd0);
            end else begin
                chk("sb_data", 64'(lnk.dst_data), 64'(sb_q[0]));
                void'(sb_q.pop_front());
                pops++;
            end
        end
        if (lnk.src_EN) begin
            sb_q.push_back(lnk.src_data);
            seq++;
        end
        tick();
    endtask

    initial begin
        RST = 1'b0;
        lnk.enable = 1'b1; lnk.src_RDY = 1'b1; lnk.dst_RDY = 1'b1; lnk.src_data = 32'd1;
        lnk4.enable = 1'b0; lnk4.src_RDY = 1'b0; lnk4.dst_RDY = 1'b0; lnk4.src_data = 8'd0;

        // reset: methods gated off, state cleared
        #1;
        chk("rst_src_en", 64'(lnk.src_EN), 64'd0);
        chk("rst_dst_en", 64'(lnk.dst_EN), 64'd0);
        tick();
        tick();
        chk("rst_occ", 64'(lnk.occupancy), 64'd0);
        chk("rst_delivered", 64'(lnk.delivered), 64'd0);
        RST = 1'b1;

        // full-rate streaming 1,2,3,...
        for (int k = 1; k <= 6; k++) begin
            lnk.src_data = 32'(k);
            #1;
            chk("st_src_en", 64'(lnk.src_EN), 64'd1);
            chk("st_dst_en", 64'(lnk.dst_EN), 64'(k > 1));
            if (k > 1) chk("st_dst_data", 64'(lnk.dst_data), 64'(k - 1));
            chk("st_occ", 64'(lnk.occupancy), (k > 1) ? 64'd1 : 64'd0);
            chk("st_delivered", 64'(lnk.delivered), (k > 1) ? 64'(k - 2) : 64'd0);
            tick();
        end

        // drain the last streamed word with enable low
        lnk.enable = 1'b0;
        #1;
        chk("dr_src_en", 64'(lnk.src_EN), 64'd0);
        chk("dr_dst_data", 64'(lnk.dst_data), 64'd6);
        tick();
        chk("dr_occ", 64'(lnk.occupancy), 64'd0);
        chk("dr_dst_en", 64'(lnk.dst_EN), 64'd0);
        chk("dr_delivered", 64'(lnk.delivered), 64'd6);

        // backpressure: fill with A,B then release
        lnk.enable = 1'b1; lnk.dst_RDY = 1'b0; lnk.src_data = 32'hA;
        #1; chk("bp_pull_a", 64'(lnk.src_EN), 64'd1);
        tick();
        lnk.src_data = 32'hB;
        #1; chk("bp_pull_b", 64'(lnk.src_EN), 64'd1);
        tick();
        lnk.src_data = 32'hC;
        #1;
        chk("bp_full_src_en", 64'(lnk.src_EN), 64'd0);
        chk("bp_full_occ", 64'(lnk.occupancy), 64'd2);
        chk("bp_full_dst_en", 64'(lnk.dst_EN), 64'd0);
        chk("bp_head", 64'(lnk.dst_data), 64'hA);
        tick();
        chk("bp_hold_occ", 64'(lnk.occupancy), 64'd2);
        lnk.dst_RDY = 1'b1;
        #1;
        chk("bp_bubble_src_en", 64'(lnk.src_EN), 64'd0);
        chk("bp_bubble_dst_en", 64'(lnk.dst_EN), 64'd1);
        chk("bp_deliver_a", 64'(lnk.dst_data), 64'hA);
        tick();
        chk("bp_occ1", 64'(lnk.occupancy), 64'd1);
        chk("bp_cnt7", 64'(lnk.delivered), 64'd7);
        chk("bp_resume_src", 64'(lnk.src_EN), 64'd1);
        chk("bp_deliver_b", 64'(lnk.dst_data), 64'hB);
        tick();
        lnk.src_data = 32'hD;
        #1;
        chk("bp_cnt8", 64'(lnk.delivered), 64'd8);
        chk("bp_deliver_c", 64'(lnk.dst_data), 64'hC);
        tick();

        // occupancy 2 then enable low: drains two, pulls none
        lnk.dst_RDY = 1'b0; lnk.src_data = 32'hE;
        #1; chk("en_pull_e", 64'(lnk.src_EN), 64'd1);
        tick();
        lnk.enable = 1'b0; lnk.dst_RDY = 1'b1;
        #1;
        chk("en_occ2", 64'(lnk.occupancy), 64'd2);
        chk("en_src_off", 64'(lnk.src_EN), 64'd0);
        chk("en_deliver_d", 64'(lnk.dst_data), 64'hD);
        tick();
        chk("en_src_off2", 64'(lnk.src_EN), 64'd0);
        chk("en_deliver_e", 64'(lnk.dst_data), 64'hE);
        tick();
        chk("en_occ0", 64'(lnk.occupancy), 64'd0);
        chk("en_dst_off", 64'(lnk.dst_EN), 64'd0);
        chk("en_cnt11", 64'(lnk.delivered), 64'd11);

        // random handshakes against an ordering scoreboard
        lnk.enable = 1'b1;
        for (int i = 0; i < 300; i++) begin
            lnk.src_RDY  = 1'($urandom_range(0, 1));
            lnk.dst_RDY  = 1'($urandom_range(0, 1));
            lnk.src_data = 32'(seq);
            sb_cycle();
        end
        lnk.src_RDY = 1'b0; lnk.dst_RDY = 1'b1;
        for (int i = 0; i < 4; i++) sb_cycle();
        chk("rnd_sb_empty", 64'(sb_q.size()), 64'd0);
        chk("rnd_occ0", 64'(lnk.occupancy), 64'd0);
        chk("rnd_delivered", 64'(lnk.delivered), 64'(16'(11 + pops)));

        // reset while full discards both words
        lnk.src_RDY = 1'b1; lnk.dst_RDY = 1'b0; lnk.src_data = 32'h20;
        tick();
        lnk.src_data = 32'h21;
        tick();
        chk("rs_occ2", 64'(lnk.occupancy), 64'd2);
        RST = 1'b0; lnk.dst_RDY = 1'b1; lnk.src_data = 32'h22;
        #1;
        chk("rs_src_gated", 64'(lnk.src_EN), 64'd0);
        chk("rs_dst_gated", 64'(lnk.dst_EN), 64'd0);
        tick();
        RST = 1'b1; lnk.src_data = 32'h30;
        #1;
        chk("rs_occ0", 64'(lnk.occupancy), 64'd0);
        chk("rs_cnt0", 64'(lnk.delivered), 64'd0);
        chk("rs_first_pull", 64'(lnk.src_EN), 64'd1);
        chk("rs_no_push", 64'(lnk.dst_EN), 64'd0);
        tick();
        lnk.src_RDY = 1'b0;
        #1;
        chk("rs_push_en", 64'(lnk.dst_EN), 64'd1);
        chk("rs_new_word", 64'(lnk.dst_data), 64'h30);
        tick();
        chk("rs_cnt1", 64'(lnk.delivered), 64'd1);

        // 4-bit delivered counter wraps
        lnk4.enable = 1'b1; lnk4.src_RDY = 1'b1; lnk4.dst_RDY = 1'b1;
        for (int e = 1; e <= 18; e++) begin
            lnk4.src_data = 8'(e);
            tick();
            if (e == 16) chk("wrap_15", 64'(lnk4.delivered), 64'hF);
            if (e == 17) chk("wrap_16", 64'(lnk4.delivered), 64'h0);
            if (e == 18) begin
                chk("wrap_17", 64'(lnk4.delivered), 64'h1);
                chk("wrap_head", 64'(lnk4.dst_data), 64'd18);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule

`default_nettype wire
